// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one two-stage borrow cell stepped LSB-first
// over WIDTH cycles, framed by a start/busy/done handshake.
module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-2:0] r_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_bq;
    logic             r_borrow;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_last;
    logic [1:0]       w_hs1;
    logic [1:0]       w_hs2;
    logic             w_dbit;
    logic             w_bnext;
    logic [WIDTH-1:0] w_sr_next;

    // Half subtractor x - y: returns {borrow, difference}.
    function automatic logic [1:0] half_sub(input logic x, input logic y);
        return {~x & y, x ^ y};
    endfunction

    always_comb begin
        w_hs1     = half_sub(r_sa[0], r_sb[0]);
        w_hs2     = half_sub(w_hs1[0], r_bq);
        w_dbit    = w_hs2[0];
        w_bnext   = w_hs1[1] | w_hs2[1];
        // sr keeps only the WIDTH-1 bits already produced; the newest bit
        // completes the result on the final step.
        w_sr_next = {w_dbit, r_sr};
        w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_accept = start;
                w_next   = start ? S_RUN : S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sa     <= '0;
            r_sb     <= '0;
            r_sr     <= '0;
            r_bq     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_sa  <= a_in;
            r_sb  <= b_in;
            r_bq  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == S_RUN) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_bq  <= w_bnext;
            r_sr  <= w_sr_next[WIDTH-1:1];
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_diff   <= w_sr_next;
                r_borrow <= w_bnext;
            end
        end
    end

    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_DONE);
    assign diff       = r_diff;
    assign borrow_out = r_borrow;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed and table-driven bench for serial_subtractor_ctrl at WIDTH=8 and an
// exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_subtractor_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start4;
    logic [7:0] a8, b8;
    logic [3:0] a4, b4;
    logic       busy8, done8, bo8;
    logic       busy4, done4, bo4;
    logic [7:0] diff8;
    logic [3:0] diff4;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [7:0] prev_d;
    logic       prev_b;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] d;
        logic       bo;
    } vec_t;

    vec_t tbl [9];

    serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_subtractor_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4),
        .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One full WIDTH=8 operation; outputs must hold the previous result during RUN.
    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] ed, input logic eb);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            start8 = 1'b0;
            a8 = 8'hxx; b8 = 8'hxx;
            if (k < 8) begin
                chk("run_busy", 32'(busy8), 32'd1);
                chk("run_done", 32'(done8), 32'd0);
                chk("run_hold_diff", 32'(diff8), 32'(prev_d));
                chk("run_hold_borrow", 32'(bo8), 32'(prev_b));
            end else begin
                chk("end_done", 32'(done8), 32'd1);
                chk("end_busy", 32'(busy8), 32'd0);
                chk("end_diff", 32'(diff8), 32'(ed));
                chk("end_borrow", 32'(bo8), 32'(eb));
            end
        end
        @(negedge clk);
        chk("idle_done", 32'(done8), 32'd0);
        chk("idle_busy", 32'(busy8), 32'd0);
        prev_d = ed;
        prev_b = eb;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] ed;
        ed = a - b;
        @(negedge clk);
        a4 = a; b4 = b; start4 = 1'b1;
        for (int k = 0; k <= 4; k++) begin
            @(negedge clk);
            start4 = 1'b0;
            if (k == 0) chk("w4_busy", 32'(busy4), 32'd1);
        end
        chk("w4_done", 32'(done4), 32'd1);
        chk("w4_diff", 32'(diff4), 32'(ed));
        chk("w4_borrow", 32'(bo4), 32'(a < b));
    endtask

    initial begin
        tbl[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
        tbl[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
        tbl[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
        tbl[3] = '{8'h80, 8'h01, 8'h7F, 1'b0};
        tbl[4] = '{8'h10, 8'h20, 8'hF0, 1'b1};
        tbl[5] = '{8'h20, 8'h10, 8'h10, 1'b0};
        tbl[6] = '{8'h00, 8'h00, 8'h00, 1'b0};
        tbl[7] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
        tbl[8] = '{8'h01, 8'hFF, 8'h02, 1'b1};

        rst = 1'b1; start8 = 1'b1; start4 = 1'b1;
        a8 = 8'hAA; b8 = 8'h55; a4 = 4'h3; b4 = 4'h1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_diff", 32'(diff8), 32'd0);
        chk("rst_borrow", 32'(bo8), 32'd0);
        chk("rst_busy4", 32'(busy4), 32'd0);
        start8 = 1'b0; start4 = 1'b0;
        rst = 1'b0;
        prev_d = 8'h00; prev_b = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 32'(busy8), 32'd0);

        for (int i = 0; i < 9; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].d, tbl[i].bo);
        end

        // start re-asserted during RUN with new operands must be ignored
        @(negedge clk);
        a8 = 8'h80; b8 = 8'h01; start8 = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 10; k++) begin
            chk("ign_done", 32'(done8), 32'(k == 8));
            chk("ign_busy", 32'(busy8), 32'(k < 8));
            if (k == 8) begin
                chk("ign_diff", 32'(diff8), 32'h7F);
                chk("ign_borrow", 32'(bo8), 32'd0);
            end
            if (k == 2) begin
                start8 = 1'b1; a8 = 8'h00; b8 = 8'hFF;
            end else begin
                start8 = 1'b0;
            end
            @(negedge clk);
        end
        prev_d = 8'h7F; prev_b = 1'b0;

        // start held high: back-to-back operations
        a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        @(negedge clk);
        for (int k = 0; k <= 18; k++) begin
            chk("b2b_done", 32'(done8), 32'(k == 8 || k == 17));
            chk("b2b_busy", 32'(busy8), 32'((k < 8) || (k > 8 && k < 17)));
            if (k < 8) begin
                chk("b2b_diff0", 32'(diff8), 32'(prev_d));
            end else if (k < 17) begin
                chk("b2b_diff1", 32'(diff8), 32'hF0);
                chk("b2b_borrow1", 32'(bo8), 32'd1);
            end else begin
                chk("b2b_diff2", 32'(diff8), 32'h10);
                chk("b2b_borrow2", 32'(bo8), 32'd0);
            end
            if (k == 8) begin
                a8 = 8'h20; b8 = 8'h10;
            end
            if (k == 17) start8 = 1'b0;
            @(negedge clk);
        end
        prev_d = 8'h10; prev_b = 1'b0;

        // reset in the middle of RUN aborts without a done pulse
        a8 = 8'h5A; b8 = 8'h3C; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy8), 32'd0);
        chk("abort_done", 32'(done8), 32'd0);
        chk("abort_diff", 32'(diff8), 32'd0);
        chk("abort_borrow", 32'(bo8), 32'd0);
        begin
            int seen;
            seen = 0;
            for (int k = 0; k < 12; k++) begin
                @(negedge clk);
                seen += int'(done8) + int'(busy8);
            end
            chk("abort_no_done", 32'(seen), 32'd0);
        end
        prev_d = 8'h00; prev_b = 1'b0;
        op8(8'h5A, 8'h3C, 8'h1E, 1'b0);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(4'(a), 4'(b));
            end
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb, rd;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rd = ra - rb;
            op8(ra, rb, rd, ra < rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/serial_subtractor_ctrl.md
# serial_subtractor_ctrl

Bit-serial subtraction sequencer. It computes an unsigned WIDTH-bit difference A − B by stepping a single one-bit borrow cell, built from two half-subtractor stages, LSB-first over WIDTH cycles. A registered borrow carries between cycles, and a start/busy/done handshake frames each operation. It is the sequencing controller for the team's subtractor datapath and trades latency for area against a parallel ripple subtractor.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- a_in  in  WIDTH  minuend; captured on the accepting edge only.
- b_in  in  WIDTH  subtrahend; captured on the accepting edge only.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; high only in DONE.
- diff  out  WIDTH  registered result (A − B) mod 2^WIDTH.
- borrow_out  out  1  final borrow; 1 iff A < B unsigned.

## Operation
- States:
  - IDLE: waiting for a request.
  - RUN: WIDTH bit-steps.
  - DONE: one cycle with done=1.
- Accepting edge: start=1 while in IDLE or DONE. On this edge:
  - a_in and b_in load into shift registers sa and sb.
  - The internal borrow register bq clears to 0.
  - The bit counter cnt clears to 0.
  - State goes to RUN.
- RUN, per edge, using current LSBs sa[0] and sb[0]:
  - Stage 1: d1 = sa[0]^sb[0], b1 = ~sa[0]&sb[0].
  - Stage 2: dbit = d1^bq, b2 = ~d1&bq.
  - bq ← b1|b2.
  - sa and sb shift right by 1.
  - dbit shifts into the MSB of the internal result shift register sr.
  - cnt increments.
- RUN exit: on the edge where cnt = WIDTH−1, which processes the last bit:
  - diff ← final sr contents, with this edge's dbit included as the MSB.
  - borrow_out ← b1|b2 of this edge.
  - State goes to DONE.
- DONE → IDLE when start=0. DONE → RUN when start=1 (back-to-back; new operands captured).
- start in RUN is ignored. Operands are not re-sampled and there is no queueing.
- diff and borrow_out change only at the RUN-exit edge and at reset. They hold the last result indefinitely otherwise, including during a following RUN.
- a_in and b_in are don't-care on every edge except the accepting edge.
- Arithmetic: unsigned modulo 2^WIDTH. There is no overflow flag; borrow_out is the sole out-of-range indicator.

## Timing
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, diff=0, borrow_out=0.
  - sa, sb, sr, bq and cnt all clear to 0.
  - rst overrides start in the same cycle.
- Reset during RUN aborts the operation. diff and borrow_out go to 0, not to a partial result, and no done pulse follows.
- Latency, with the accepting edge as E0:
  - busy is high in cycles after E0 through after E(WIDTH−1).
  - diff and borrow_out are valid after E(WIDTH).
  - done is high for exactly the one cycle after E(WIDTH).
- Start-to-done: WIDTH+1 edges.
- Throughput: one result per WIDTH+1 cycles with back-to-back start.
- busy and done are never high together. busy is 0 in IDLE and DONE.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Reset then WIDTH=8, a_in=0x5A, b_in=0x3C, start pulsed one cycle → busy high 8 cycles, then done one cycle; diff=0x1E, borrow_out=0.
- a_in=0x00, b_in=0x01 → diff=0xFF, borrow_out=1 (full borrow ripple through all bits). Then a_in=0xFF, b_in=0xFF → diff=0x00, borrow_out=0.
- Start a_in=0x80, b_in=0x01; re-assert start with a_in=0x00, b_in=0xFF at cycle 3 of RUN → ignored; diff=0x7F, borrow_out=0, single done pulse at edge 9.
- Start held high continuously with a_in=0x10, b_in=0x20 then a_in=0x20, b_in=0x10 presented at the DONE cycle → first done gives diff=0xF0/borrow_out=1; RUN restarts immediately, second done 9 edges later gives diff=0x10/borrow_out=0; diff holds 0xF0 throughout second RUN.
- rst asserted at cycle 4 of RUN → next cycle busy=0, done=0, diff=0x00, borrow_out=0, state IDLE; no done pulse follows; next start runs normally.
- Randomised sweep, WIDTH=4 exhaustive (256 pairs) and WIDTH=8 random → diff equals (a−b) mod 2^WIDTH and borrow_out equals (a<b) for every operation.
